// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: optional input synchroniser, per-channel edge mode,
// retriggerable fixed-length output pulse, sticky event flag with software clear.
module edge_detect_multi #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 2,
  parameter int CNT_W       = $clog2(PULSE_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   out,
  output logic [CHANNELS-1:0]   sticky,
  output logic                  edge_any
);

  localparam int unsigned WU_MAX = SYNC_STAGES + 1;
  localparam int unsigned WU_W   = $clog2(WU_MAX + 1);

  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] prev_q;
  logic [CHANNELS-1:0] det;

  logic [WU_W-1:0] wu_q, wu_d;
  logic            wu_done;

  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0] out_q, out_d;
  logic [CHANNELS-1:0] sticky_q, sticky_d;
  logic                any_q, any_d;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;

      always_ff @(posedge clk) begin
        if (!reset) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= in;
          for (int unsigned st = 1; st < SYNC_STAGES; st++) begin
            sync_q[st] <= sync_q[st-1];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Detection stays off until prev holds a genuinely sampled value, so a line
  // already high at reset release never looks like a rising edge.
  assign wu_done = (wu_q == WU_MAX[WU_W-1:0]);
  assign wu_d    = wu_done ? wu_q : wu_q + 1'b1;

  always_comb begin
    det      = '0;
    cnt_d    = cnt_q;
    out_d    = '0;
    sticky_d = sticky_q;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      det[ch] = wu_done &
                ((mode[2*ch]   & s[ch] & ~prev_q[ch]) |
                 (mode[2*ch+1] & ~s[ch] & prev_q[ch]));
      if (det[ch]) begin
        cnt_d[ch] = PULSE_LEN[CNT_W-1:0];
      end else if (cnt_q[ch] != '0) begin
        cnt_d[ch] = cnt_q[ch] - 1'b1;
      end
      out_d[ch]    = (cnt_d[ch] != '0);
      sticky_d[ch] = (sticky_q[ch] & ~clear[ch]) | det[ch];
    end
    any_d = |out_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q   <= '0;
      wu_q     <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      sticky_q <= '0;
      any_q    <= 1'b0;
    end else begin
      prev_q   <= s;
      wu_q     <= wu_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      sticky_q <= sticky_d;
      any_q    <= any_d;
    end
  end

  assign out      = out_q;
  assign sticky   = sticky_q;
  assign edge_any = any_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Randomised bench for edge_detect_multi: two parameterisations driven with the same
// stimulus, each compared every cycle against an edge-history reference model.
module tb_edge_detect_multi;

  localparam int CH   = 4;
  localparam int N0   = 2;
  localparam int P0   = 2;
  localparam int N1   = 0;
  localparam int P1   = 4;
  localparam int HMAX = 8192;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [CH-1:0]     in_v;
  logic [2*CH-1:0]   mode_v;
  logic [CH-1:0]     clear_v;
  logic [CH-1:0]     out0, stk0, out1, stk1;
  logic              any0, any1;

  edge_detect_multi #(.CHANNELS(CH), .SYNC_STAGES(N0), .PULSE_LEN(P0)) u_dut0 (
    .clk(clk), .reset(rst_n), .in(in_v), .mode(mode_v), .clear(clear_v),
    .out(out0), .sticky(stk0), .edge_any(any0)
  );

  edge_detect_multi #(.CHANNELS(CH), .SYNC_STAGES(N1), .PULSE_LEN(P1)) u_dut1 (
    .clk(clk), .reset(rst_n), .in(in_v), .mode(mode_v), .clear(clear_v),
    .out(out1), .sticky(stk1), .edge_any(any1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: input history per post-reset edge, last detection edge per channel.
  logic [CH-1:0] hist [2][HMAX];
  int            ecnt [2];
  int            last_det [2][CH];
  logic [CH-1:0] stk_m [2];

  task automatic model_step(input int k, input int n, input logic rst,
                            input logic [CH-1:0] iv, input logic [2*CH-1:0] mv,
                            input logic [CH-1:0] cv);
    logic [CH-1:0] cur, prv, det;
    int e;
    if (!rst) begin
      ecnt[k]  = 0;
      stk_m[k] = '0;
      for (int c = 0; c < CH; c++) last_det[k][c] = -1;
    end else begin
      if (ecnt[k] < HMAX - 1) ecnt[k]++;
      e = ecnt[k];
      hist[k][e] = iv;
      det = '0;
      if (e >= n + 2) begin
        cur = hist[k][e-n];
        prv = hist[k][e-n-1];
        for (int c = 0; c < CH; c++) begin
          if ((cur[c] && !prv[c] && mv[2*c]) || (!cur[c] && prv[c] && mv[2*c+1])) begin
            det[c] = 1'b1;
            last_det[k][c] = e;
          end
        end
      end
      stk_m[k] = (stk_m[k] & ~cv) | det;
    end
  endtask

  function automatic logic [CH-1:0] exp_out(input int k, input int pl);
    logic [CH-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++)
      r[c] = (last_det[k][c] >= 0) && (ecnt[k] - last_det[k][c] < pl);
    return r;
  endfunction

  initial begin
    int rst_hold;
    int phase;
    logic [CH-1:0] eo;
    rst_hold = 0;
    rst_n    = 1'b0;
    in_v     = '1;
    mode_v   = '1;
    clear_v  = '0;
    for (int k = 0; k < 2; k++) begin
      ecnt[k]  = 0;
      stk_m[k] = '0;
      for (int c = 0; c < CH; c++) last_det[k][c] = -1;
    end

    for (int cyc = 0; cyc <= NCYC; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        eo = exp_out(0, P0);
        check($sformatf("c%0d out0", cyc), 32'(out0), 32'(eo));
        check($sformatf("c%0d sticky0", cyc), 32'(stk0), 32'(stk_m[0]));
        check($sformatf("c%0d any0", cyc), 32'(any0), 32'(|eo));
        eo = exp_out(1, P1);
        check($sformatf("c%0d out1", cyc), 32'(out1), 32'(eo));
        check($sformatf("c%0d sticky1", cyc), 32'(stk1), 32'(stk_m[1]));
        check($sformatf("c%0d any1", cyc), 32'(any1), 32'(|eo));
      end
      if (cyc == NCYC) break;

      if (cyc < 4) begin
        // lines held high through reset and release: no edge may be reported
        rst_n   = 1'b0;
        in_v    = '1;
        mode_v  = '1;
        clear_v = '0;
      end else if (cyc < 20) begin
        rst_n   = 1'b1;
        clear_v = '0;
      end else begin
        if (rst_hold > 0) begin
          rst_hold--;
          rst_n = 1'b0;
        end else if ($urandom_range(0, 119) == 0) begin
          rst_hold = $urandom_range(0, 2);
          rst_n    = 1'b0;
        end else begin
          rst_n = 1'b1;
        end
        phase = (cyc / 250) % 4;
        case (phase)
          0: for (int c = 0; c < CH; c++) if ($urandom_range(0, 1) == 0) in_v[c] = ~in_v[c];
          1: for (int c = 0; c < CH; c++) if ($urandom_range(0, 7) == 0) in_v[c] = ~in_v[c];
          2: in_v = ~in_v;
          default: for (int c = 0; c < CH; c++) if ($urandom_range(0, 19) == 0) in_v[c] = ~in_v[c];
        endcase
        if (phase == 2 && (cyc % 250) < 60) mode_v = '1;
        else if ($urandom_range(0, 29) == 0) mode_v = 8'($urandom);
        for (int c = 0; c < CH; c++) clear_v[c] = ($urandom_range(0, 7) == 0);
      end

      model_step(0, N0, rst_n, in_v, mode_v, clear_v);
      model_step(1, N1, rst_n, in_v, mode_v, clear_v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
